div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Upstream sequencer for the iterative 64-bit divider in the EX stage.
- Accepts RV64M divide/remainder ops from EX and prepares unsigned operand magnitudes.
- Resolves the RISC-V special cases (divide-by-zero, signed overflow) without starting the divider.
- Starts the divider for all other ops, waits for completion, applies sign and W-variant correction, and returns one 64-bit result while stalling the pipeline.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- OP_W, 3, width of the op code field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  EX presents a divide-class op this cycle
- in_op  in  3  0 DIV, 1 DIVU, 2 REM, 3 REMU, 4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW
- in_rs1  in  64  dividend operand
- in_rs2  in  64  divisor operand
- flush  in  1  kill the in-flight op (branch/trap redirect)
- ex_stall  out  1  hold EX/upstream stages
- res_valid  out  1  result valid, one-cycle pulse
- res_data  out  64  final rd value
- div_start  out  1  one-cycle start pulse to the divider
- div_kill  out  1  abort the divider
- div_dividend  out  64  |dividend|, stable from div_start until div_done
- div_divisor  out  64  |divisor|, stable from div_start until div_done
- div_done  in  1  divider completion pulse
- div_quot  in  64  unsigned quotient
- div_rem  in  64  unsigned remainder

Behaviour:
- Reset: state IDLE; all outputs 0; operand/result registers 0.
- FSM states: IDLE, CHECK, WAIT, DONE.
- IDLE: when in_valid and not flush, latch in_op, in_rs1, in_rs2 and go to CHECK.
- Operand prep for W ops: use bits [31:0] only. Signed ops sign-extend them to 64 bits; unsigned ops zero-extend.
- Operand prep for non-W ops: signed ops treat the operands as two's complement; unsigned ops use them as-is.
- Magnitudes are the absolute values of the prepared operands; unsigned operands pass through unchanged.
- CHECK, divisor (prepared) == 0:
  - DIV/DIVU/DIVW/DIVUW give all-ones (0xFFFF_FFFF_FFFF_FFFF).
  - REM/REMU give rs1.
  - REMW/REMUW give sext(rs1[31:0]).
  - Go to DONE.
- CHECK, signed overflow (DIV with rs1=0x8000_0000_0000_0000 and rs2=-1, or DIVW with rs1[31:0]=0x8000_0000 and rs2[31:0]=0xFFFF_FFFF):
  - Quotient = dividend (DIVW: 0xFFFF_FFFF_8000_0000).
  - Remainder = 0.
  - Go to DONE.
- CHECK, otherwise: drive div_dividend/div_divisor, pulse div_start for exactly this cycle, go to WAIT.
- WAIT: on div_done, capture div_quot/div_rem and go to DONE. No timeout.
- Sign fix (computed in DONE from captured values):
  - Negate the quotient iff the op is signed, the quotient is selected, and the prepared operand signs differ.
  - Negate the remainder iff the op is signed, the remainder is selected, and the prepared dividend is negative.
  - W ops: sign-extend bit 31 of the corrected 32-bit result.
- DONE: res_valid=1 and res_data valid for exactly one cycle, then IDLE. A new in_valid is accepted no earlier than the cycle after DONE.
- ex_stall = (state==IDLE & in_valid) | state==CHECK | state==WAIT. ex_stall is 0 in DONE so EX advances with the result.
- Latency:
  - Special case: accept edge to res_valid is 2 cycles.
  - Normal case: 2 cycles + divider latency.
- flush in CHECK/WAIT/DONE: next state IDLE; res_valid suppressed.
  - div_kill pulses for 1 cycle if flush occurs in WAIT.
  - A div_done arriving in the same cycle as the flush is discarded.
- flush and in_valid together in IDLE: the op is not accepted.
- rst in any state: IDLE next cycle, div_kill not asserted. The divider is reset by the same rst.
- res_data holds its last value when res_valid=0.

Optional Feature:
- Macro DIV_RESULT_REUSE_EN.
- When defined: keep the last divider-produced {signed-ness, W-ness, prepared operands, quotient, remainder}, with a valid bit.
  - In CHECK, if the new op matches the stored operands and class (e.g. REM after DIV), skip the divider and go straight to DONE using the stored values.
  - The valid bit is cleared by rst, by flush during WAIT, and by special-case ops.
- When undefined: every non-special op starts the divider; no reuse storage exists.

Test Plan:
- DIV rs1=-7, rs2=2 -> one div_start with div_dividend=7, div_divisor=2; after div_done, res_data=0xFFFF_FFFF_FFFF_FFFD (-3); REM of the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU rs1=100, rs2=0 -> no div_start; res_valid 2 cycles after accept; res_data=0xFFFF_FFFF_FFFF_FFFF. REMUW rs1=0x1_8000_0001, rs2=0 -> res_data=0xFFFF_FFFF_8000_0001.
- DIV rs1=0x8000_0000_0000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF -> res_data=0x8000_0000_0000_0000; REM of the same operands -> 0; no div_start in either case.
- DIVW rs1=0x0000_0000_FFFF_FFF0 (-16), rs2=3 -> res_data=0xFFFF_FFFF_FFFF_FFFB (-5); DIVUW with the same operands -> 0x0000_0000_5555_5550.
- Flush while in WAIT -> div_kill pulses once, no res_valid, ex_stall drops the next cycle; the next DIVU 9/3 returns 3.
- With DIV_RESULT_REUSE_EN: DIV 20/6 then REM 20/6 -> only one div_start total; results 3 and 2. Without the macro -> two div_start pulses.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Sequencer in front of the iterative 64-bit divider: preps magnitudes, resolves RV64M special
// cases locally and applies sign/W correction. Optional feature macro: DIV_RESULT_REUSE_EN.
module div_issue_ctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            ex_stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            div_start,
  output logic            div_kill,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem
);

  typedef enum logic [1:0] {StIdle, StCheck, StWait, StDone} state_e;

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, quot_q, rem_q, hold_q;
  logic            fix_en_q;

  logic            is_sg, is_rem, is_w;
  logic [XLEN-1:0] a_p, b_p;
  logic            a_neg, b_neg, div0, ovf, special, reuse_hit, neg;
  logic [XLEN-1:0] sel, fixed, final_res, ru_quot, ru_rem;

  assign is_sg  = ~op_q[0];
  assign is_rem = op_q[1];
  assign is_w   = op_q[2];

  always_comb begin
    a_p = rs1_q;
    b_p = rs2_q;
    if (is_w) begin
      a_p = {{(XLEN-32){is_sg & rs1_q[31]}}, rs1_q[31:0]};
      b_p = {{(XLEN-32){is_sg & rs2_q[31]}}, rs2_q[31:0]};
    end
  end

  assign a_neg        = is_sg & a_p[XLEN-1];
  assign b_neg        = is_sg & b_p[XLEN-1];
  assign div_dividend = a_neg ? -a_p : a_p;
  assign div_divisor  = b_neg ? -b_p : b_p;

  assign div0    = (b_p == '0);
  assign ovf     = is_sg & (&b_p) &
                   (is_w ? (a_p[31:0] == 32'h8000_0000) : (a_p == {1'b1, {(XLEN-1){1'b0}}}));
  assign special = div0 | ovf;

  // Special-case results are already final, so sign correction is disabled for them.
  assign sel       = is_rem ? rem_q : quot_q;
  assign neg       = fix_en_q & is_sg & (is_rem ? a_neg : (a_neg ^ b_neg));
  assign fixed     = neg ? -sel : sel;
  assign final_res = is_w ? {{(XLEN-32){fixed[31]}}, fixed[31:0]} : fixed;

`ifdef DIV_RESULT_REUSE_EN
  logic            ru_vld_q, ru_sg_q, ru_w_q;
  logic [XLEN-1:0] ru_a_q, ru_b_q, ru_quot_q, ru_rem_q;

  assign reuse_hit = ru_vld_q & (ru_sg_q == is_sg) & (ru_w_q == is_w) &
                     (ru_a_q == a_p) & (ru_b_q == b_p);
  assign ru_quot   = ru_quot_q;
  assign ru_rem    = ru_rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ru_vld_q  <= 1'b0;
      ru_sg_q   <= 1'b0;
      ru_w_q    <= 1'b0;
      ru_a_q    <= '0;
      ru_b_q    <= '0;
      ru_quot_q <= '0;
      ru_rem_q  <= '0;
    end else if (state_q == StCheck && !flush && special) begin
      ru_vld_q <= 1'b0;
    end else if (state_q == StWait && flush) begin
      ru_vld_q <= 1'b0;
    end else if (state_q == StWait && div_done) begin
      ru_vld_q  <= 1'b1;
      ru_sg_q   <= is_sg;
      ru_w_q    <= is_w;
      ru_a_q    <= a_p;
      ru_b_q    <= b_p;
      ru_quot_q <= div_quot;
      ru_rem_q  <= div_rem;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign ru_quot   = '0;
  assign ru_rem    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      hold_q   <= '0;
      fix_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && !flush) begin
            op_q    <= in_op;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (special) begin
            quot_q   <= div0 ? '1 : a_p;
            rem_q    <= div0 ? a_p : '0;
            fix_en_q <= 1'b0;
            state_q  <= StDone;
          end else if (reuse_hit) begin
            quot_q   <= ru_quot;
            rem_q    <= ru_rem;
            fix_en_q <= 1'b1;
            state_q  <= StDone;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (div_done) begin
            quot_q   <= div_quot;
            rem_q    <= div_rem;
            fix_en_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (!flush) hold_q <= final_res;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_start = ~rst & ~flush & (state_q == StCheck) & ~special & ~reuse_hit;
  assign div_kill  = ~rst & flush & (state_q == StWait);
  assign res_valid = ~rst & ~flush & (state_q == StDone);
  assign res_data  = res_valid ? final_res : hold_q;
  assign ex_stall  = ((state_q == StIdle) & in_valid) | (state_q == StCheck) |
                     (state_q == StWait);

endmodule
